uart_packet_rx: RTL and testbench
=================================

Name: uart_packet_rx

Overview:
- Serial-to-byte UART receiver, 8N1, LSB first. It sits directly upstream of the CPU instruction loader.
- Samples the asynchronous rx pin, assembles bytes, and presents each byte on uart_packet with a 4-phase packet_ready/packet_ack handshake.
- A one-byte holding register decouples serial reception from the loader's handshake. Overrun and framing errors are flagged rather than silently merged.

Parameters:
- CLKS_PER_BIT, 868: clk cycles per serial bit (100 MHz / 115200). Legal range 4..65535.
- SYNC_STAGES, 2: number of synchroniser flops on rx. Legal values 2..3.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx  input  1  serial line, idle high, asynchronous to clk.
- packet_ack  input  1  loader acknowledge; high = byte taken; must return low before the next byte is offered.
- packet_ready  output  1  holding register valid.
- uart_packet  output  8  holding register contents; stable while packet_ready is high.
- framing_error  output  1  one-cycle pulse when a stop bit is sampled low.
- overrun  output  1  sticky; a received byte was dropped because the holding register was full. Cleared only by rst.
- parity_error  output  1  see Optional Feature.

Behaviour:
- Reset (async, immediate): all outputs 0; state IDLE; counters 0; synchroniser flops set to 1 (idle line).
- Synchroniser: rx passes through SYNC_STAGES flops; rx_s is the synchronised value. Edge detection uses rx_s only.
- Counters: bit timer is 16 bits, reset on every state entry; bit index is 3 bits.
- IDLE: on rx_s == 0, go to START and clear the timer.
- START: when the timer reaches CLKS_PER_BIT/2 - 1 (mid start bit), resample rx_s.
  - rx_s == 1: false start, return to IDLE, no flags.
  - rx_s == 0: go to DATA, index 0.
- DATA: every CLKS_PER_BIT cycles, sample rx_s into shift[index] (LSB first).
  - After index 7 is sampled: go to PARITY if the macro is defined, else STOP.
- STOP: after CLKS_PER_BIT cycles, sample the stop bit.
  - Stop = 1, holding empty: load uart_packet from shift; packet_ready rises on the next clk edge (1-cycle latency from the stop sample).
  - Stop = 1, holding full: set overrun; discard the byte; holding register and packet_ready unchanged.
  - Stop = 0: pulse framing_error for 1 cycle, discard the byte, go to BREAK.
  - After a good stop bit, return to IDLE at mid stop bit, so a following start edge is caught.
- BREAK: wait until rx_s == 1, then go to IDLE. A held-low line gives exactly one framing_error pulse.
- Handshake: packet_ready is held until packet_ack is sampled high, then cleared on that edge.
  - A new byte may be loaded only when packet_ready == 0 and packet_ack == 0.
  - A byte that completes while packet_ack is still high is treated as holding-full (overrun).
  - packet_ack high while packet_ready is low is ignored.
- Simultaneous events: if a stop sample coincides with packet_ready clearing, the holding register counts as full that cycle, so overrun is set. Only one byte occupancy; no FIFO.
- Reset mid-frame: the frame is abandoned. After rst releases, a line still low is seen as a start edge; the resulting garbage is caught as a false start or framing error.

Optional Feature:
- Macro: UART_PACKET_RX_PARITY_EN.
- Defined: a PARITY state follows DATA; it samples one bit after CLKS_PER_BIT cycles. Even parity is required: XOR of data[7:0] and the parity bit must be 0.
  - On mismatch, parity_error pulses 1 cycle in the same cycle the stop bit is sampled, and the byte is discarded (not loaded, no overrun).
  - Stop-bit rules are unchanged.
- Not defined: 8N1 only; parity_error tied 0.

Test Plan:
- CLKS_PER_BIT=16, send 0xA5 8N1, loader acks 3 cycles after packet_ready and drops ack 2 cycles later -> uart_packet=0xA5; packet_ready high from stop-sample+1 until the ack edge; no flags.
- Three back-to-back frames FF,00,00 with the ack model active -> three handshakes, values FF,00,00 in order; loader-level check: word 0xFF0000 assembled.
- Send 0x12 then 0x34 with ack never asserted -> uart_packet stays 0x12, overrun=1 after the second stop sample, packet_ready stays 1.
- Frame 0x3C with stop bit driven low for 40 cycles -> exactly one framing_error pulse; no packet_ready; next valid frame 0x55 received correctly.
- 5-cycle low glitch on rx while idle -> false start; returns to IDLE; no outputs change.
- rst pulsed at data bit 4 of a frame, then a clean frame 0x81 -> all outputs 0 during reset; 0x81 received.
- With UART_PACKET_RX_PARITY_EN: 0x07 with parity bit 1, then 0x07 with parity bit 0 -> first frame accepted; second gives a parity_error pulse and no packet_ready.

Source files
------------

// File: rtl/uart_packet_rx.sv
// 8N1 UART receiver feeding a one-byte holding register with a 4-phase ready/ack handshake.
// Define UART_PACKET_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_packet_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       packet_ack,
    output logic       packet_ready,
    output logic [7:0] uart_packet,
    output logic       framing_error,
    output logic       overrun,
    output logic       parity_error
);

    // Handshake: packet_ready stays high with uart_packet stable until packet_ack is
    // sampled high; a new byte loads only when packet_ready and packet_ack are both low.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);

    state_t                 state;
    state_t                 state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic [15:0]            timer;
    logic [2:0]             bit_idx;
    logic [7:0]             shift;
    logic                   half_done;
    logic                   bit_done;
    logic                   timer_clr;
    logic                   data_sample;
    logic                   stop_sample;
    logic                   par_ok;

    // Synchroniser resets to the idle-line level so reset never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

    assign rx_s      = sync_q[SYNC_STAGES-1];
    assign half_done = (timer == HALF_LAST);
    assign bit_done  = (timer == BIT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (!rx_s) state_nxt = START;
            START:  if (half_done) state_nxt = rx_s ? IDLE : DATA;
            DATA: begin
                if (bit_done && bit_idx == 3'd7) begin
`ifdef UART_PACKET_RX_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
                end
            end
            PARITY: if (bit_done) state_nxt = STOP;
            // A good stop bit returns to IDLE at mid-bit so the next start edge is caught.
            STOP:   if (bit_done) state_nxt = rx_s ? IDLE : BREAK;
            BREAK:  if (rx_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        timer_clr   = (state_nxt != state);
        data_sample = 1'b0;
        stop_sample = 1'b0;
        case (state)
            DATA: begin
                data_sample = bit_done;
                if (bit_done) timer_clr = 1'b1;
            end
            STOP:    stop_sample = bit_done;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer   <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            timer <= timer_clr ? 16'd0 : timer + 16'd1;
            if (state == START) begin
                bit_idx <= 3'd0;
            end
            if (data_sample) begin
                shift[bit_idx] <= rx_s;
                bit_idx        <= bit_idx + 3'd1;
            end
        end
    end

`ifdef UART_PACKET_RX_PARITY_EN
    logic par_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_bit <= 1'b0;
        end else if (state == PARITY && bit_done) begin
            par_bit <= rx_s;
        end
    end

    // Even parity: data bits and parity bit together hold an even number of ones.
    assign par_ok = ~(^shift ^ par_bit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_error <= 1'b0;
        end else begin
            parity_error <= stop_sample && !par_ok;
        end
    end
`else
    assign par_ok       = 1'b1;
    assign parity_error = 1'b0;
`endif

    // A stop sample in the same cycle the loader's ack drains the register still sees it full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            packet_ready  <= 1'b0;
            uart_packet   <= '0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            framing_error <= 1'b0;
            if (packet_ready && packet_ack) begin
                packet_ready <= 1'b0;
            end
            if (stop_sample) begin
                if (!rx_s) begin
                    framing_error <= 1'b1;
                end else if (par_ok) begin
                    if (!packet_ready && !packet_ack) begin
                        uart_packet  <= shift;
                        packet_ready <= 1'b1;
                    end else begin
                        overrun <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_packet_rx.sv
// Bench for uart_packet_rx at 16 clocks per bit: serial driver, loader ack model,
// and a scoreboard monitor that pops expected bytes as packet_ready rises.
module tb_uart_packet_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       packet_ack = 1'b0;
  logic       packet_ready;
  logic [7:0] uart_packet;
  logic       framing_error;
  logic       overrun;
  logic       parity_error;

  int tests = 0;
  int fails = 0;
  int fe_count = 0;
  int pe_count = 0;
  bit ack_en = 1'b0;
  logic [23:0] loader_word = '0;
  logic [7:0] exp_q[$];

  uart_packet_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .packet_ack(packet_ack),
    .packet_ready(packet_ready),
    .uart_packet(uart_packet),
    .framing_error(framing_error),
    .overrun(overrun),
    .parity_error(parity_error)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive_bit(input logic b, input int cycles);
    rx = b;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input int stop_cycles,
                            input logic par_b);
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(d[i], CPB);
`ifdef UART_PACKET_RX_PARITY_EN
    drive_bit(par_b, CPB);
`endif
    drive_bit(stop_b, stop_cycles);
    rx = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] d);
    send_frame(d, 1'b1, CPB, ^d);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 40 * CPB) begin
      @(negedge clk);
      budget++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // scoreboard monitor
  logic prev_ready = 1'b0;
  logic prev_fe = 1'b0;
  logic prev_pe = 1'b0;
  always @(negedge clk) begin
    if (packet_ready && !prev_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_ready: byte 0x%0h with nothing expected", uart_packet);
      end else begin
        check("packet_byte", uart_packet, exp_q.pop_front());
      end
    end
    if (framing_error) begin
      fe_count++;
      if (prev_fe) check("framing_pulse_width", 2, 1);
    end
    if (parity_error) begin
      pe_count++;
      if (prev_pe) check("parity_pulse_width", 2, 1);
    end
    prev_ready = packet_ready;
    prev_fe = framing_error;
    prev_pe = parity_error;
  end

  // loader ack model: ack 3 cycles after packet_ready, hold 2 cycles
  initial begin
    forever begin
      @(negedge clk);
      if (ack_en && packet_ready && !packet_ack) begin
        repeat (3) @(negedge clk);
        check("ready_held_before_ack", packet_ready, 1);
        loader_word = {loader_word[15:0], uart_packet};
        packet_ack = 1'b1;
        @(negedge clk);
        check("ready_cleared_on_ack", packet_ready, 0);
        @(negedge clk);
        packet_ack = 1'b0;
      end
    end
  end

  initial begin
    int fe_before;
    repeat (3) @(negedge clk);
    check("reset_ready", packet_ready, 0);
    check("reset_packet", uart_packet, 0);
    check("reset_framing", framing_error, 0);
    check("reset_overrun", overrun, 0);
    check("reset_parity", parity_error, 0);
    rst = 1'b0;
    idle_bits(2);
    ack_en = 1'b1;

    // single byte with ack handshake
    exp_q.push_back(8'hA5);
    send_good(8'hA5);
    idle_bits(2);
    drain("drain_a5");
    check("a5_overrun", overrun, 0);
    check("a5_framing_count", fe_count, 0);
    check("a5_parity_count", pe_count, 0);

    // back-to-back frames
    loader_word = '0;
    exp_q.push_back(8'hFF);
    send_good(8'hFF);
    exp_q.push_back(8'h00);
    send_good(8'h00);
    exp_q.push_back(8'h00);
    send_good(8'h00);
    idle_bits(2);
    drain("drain_b2b");
    check("loader_word", loader_word, 24'hFF0000);
    check("b2b_overrun", overrun, 0);

    // short low glitch while idle is a false start
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    idle_bits(3);
    check("glitch_ready", packet_ready, 0);
    check("glitch_framing_count", fe_count, 0);
    check("glitch_overrun", overrun, 0);

    // stop bit held low for 40 cycles, then a clean frame
    send_frame(8'h3C, 1'b0, 40, ^8'h3C);
    idle_bits(2);
    check("break_framing_count", fe_count, 1);
    check("break_ready", packet_ready, 0);
    exp_q.push_back(8'h55);
    send_good(8'h55);
    idle_bits(2);
    drain("drain_55");
    check("post_break_framing_count", fe_count, 1);

    // overrun: no ack
    ack_en = 1'b0;
    exp_q.push_back(8'h12);
    send_good(8'h12);
    idle_bits(1);
    drain("drain_12");
    check("first_hold_overrun", overrun, 0);
    check("first_hold_ready", packet_ready, 1);
    send_good(8'h34);
    idle_bits(1);
    check("overrun_set", overrun, 1);
    check("overrun_ready", packet_ready, 1);
    check("overrun_packet", uart_packet, 8'h12);

    // reset during data bit 4 of 0xF0 (line high then), then a clean frame
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, CPB);
    rx = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ready", packet_ready, 0);
    check("midrst_packet", uart_packet, 0);
    check("midrst_overrun", overrun, 0);
    check("midrst_framing", framing_error, 0);
    rst = 1'b0;
    idle_bits(3);
    ack_en = 1'b1;
    fe_before = fe_count;
    exp_q.push_back(8'h81);
    send_good(8'h81);
    idle_bits(2);
    drain("drain_81");
    check("post_rst_overrun", overrun, 0);
    check("post_rst_framing_count", fe_count, fe_before);

`ifdef UART_PACKET_RX_PARITY_EN
    // 0x07 has three ones: parity bit 1 is even, parity bit 0 is a mismatch
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, CPB, 1'b1);
    idle_bits(2);
    drain("drain_par_ok");
    check("par_ok_count", pe_count, 0);
    send_frame(8'h07, 1'b1, CPB, 1'b0);
    idle_bits(2);
    check("par_bad_count", pe_count, 1);
    check("par_bad_ready", packet_ready, 0);
    check("par_bad_overrun", overrun, 0);
`else
    check("parity_tied_low", pe_count, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
